output_writeback_unit: RTL
==========================

# output_writeback_unit

Parametrised writeback stage that accepts result vectors from the post-processing chain (matmul → norm → pool → activation) and writes them into the shared activation BRAM port. It buffers rows in a small FIFO and generates strided addresses from a programmed base. It arbitrates the single BRAM port against matmul read traffic, with reads taking priority, and reports completion after a programmed row count. It supersedes the fixed single-flop, fixed-stride writeback in the top level.

## Interface
- LANES, 4, elements per row vector
- DWIDTH, 8, bits per element
- AWIDTH, 10, BRAM address width
- FIFO_DEPTH, 4, row buffer depth (power of two, ≥2)
- CNT_WIDTH, 8, width of row count

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches base_addr, addr_stride, num_rows
- base_addr  in  AWIDTH  address of first row
- addr_stride  in  AWIDTH  address increment per row
- num_rows  in  CNT_WIDTH  rows to write for this job
- in_valid  in  1  row valid from activation stage
- in_data  in  LANES*DWIDTH  row data, lane 0 in LSBs
- in_mask  in  LANES  per-lane write enable (used only with WB_LANE_MASK_EN)
- in_ready  out  1  row accepted when in_valid && in_ready
- rd_req  in  1  matmul read request this cycle
- rd_addr  in  AWIDTH  matmul read address
- bram_addr  out  AWIDTH  BRAM port address
- bram_wdata  out  LANES*DWIDTH  BRAM write data
- bram_we  out  LANES  BRAM lane write enables
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ACTIVE, DONE.
- IDLE: in_ready=0. On start, latch config, clear counters, set wr_addr=base_addr, and go to ACTIVE. If num_rows==0, go directly to DONE.
- ACTIVE: accept rows into the FIFO while accepted<num_rows and the FIFO is not full. Once accepted==num_rows, in_ready=0.
- Pop condition: pop = ACTIVE && FIFO non-empty && !rd_req. On a pop, in the same cycle: bram_we=lane enables, bram_addr=wr_addr, bram_wdata=FIFO head. Then wr_addr+=addr_stride (modulo 2^AWIDTH, wraps silently) and written++.
- When not popping: bram_we=0, bram_addr=rd_addr, bram_wdata=0.
- ACTIVE→DONE on the cycle after the pop that makes written==num_rows. DONE lasts one cycle with done=1, then returns to IDLE.
- busy=1 in ACTIVE and DONE.
- start while not in IDLE is ignored.
- Simultaneous push and pop on a full FIFO: the push is allowed, because in_ready uses registered full and a pop frees a slot combinationally. Push with pop on an empty FIFO does not bypass; the row is written no earlier than the next cycle.

## Timing
- Reset values: in_ready=0, busy=0, done=0, bram_we=0, bram_wdata=0, bram_addr=rd_addr. FIFO is flushed, counters are cleared, state=IDLE.
- Reset mid-job abandons the job with no done pulse.
- Minimum latency: row accepted in cycle N is written in cycle N+1 if rd_req=0.
- Throughput is 1 row/cycle with rd_req=0.
- An asserted rd_req stalls writes indefinitely. Rows back up into the FIFO, and in_ready drops when the FIFO is full.
- done asserts 1 cycle after the last write.
- start→done is num_rows+2 cycles minimum (num_rows=0: done at start+1).

## Configuration
- WB_LANE_MASK_EN defined: bram_we = in_mask captured with each row and stored in the FIFO (LANES extra bits per entry). A row with an all-zero mask still consumes an address and counts as written.
- WB_LANE_MASK_EN undefined: in_mask is ignored, not stored, and bram_we = all ones on every pop.

## Structure
- Package wb_pkg holds the state enum (IDLE/ACTIVE/DONE) and default constants for LANES, DWIDTH, AWIDTH, FIFO_DEPTH, CNT_WIDTH.
- Sub-module wb_fifo is a synchronous FIFO parametrised by width and depth. It has push, pop, head, full and empty, with registered full/empty and a pointer with an extra wrap bit.
- The top-level FSM, counters and address generator live in output_writeback_unit.

## Test plan
- Basic job: base=0x10, stride=4, num_rows=4; stream 4 rows back to back with rd_req=0 → writes at 0x10, 0x14, 0x18, 0x1C on consecutive cycles, and done 1 cycle after the last write.
- Read priority: hold rd_req=1 for 6 cycles during a 4-row job with FIFO_DEPTH=4 → bram_addr=rd_addr and bram_we=0 throughout, in_ready drops after 4 rows, and all 4 rows drain in order once rd_req falls.
- Wrap: AWIDTH=10, base=0x3FC, stride=4, num_rows=2 → writes at 0x3FC then 0x000.
- Zero rows and excess input: num_rows=0 → done at start+1 with no writes. num_rows=2 with 3 rows offered → only 2 accepted and in_ready=0 afterwards.
- Reset mid-job after 2 of 4 rows → all outputs return to reset values, no done pulse, and a new job starting at base=0x40 writes correctly from 0x40.
- WB_LANE_MASK_EN: mask 4'b0101 on row 0 → bram_we=4'b0101 for that write. With the macro undefined, the same stimulus gives bram_we=4'b1111.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default sizing for the output writeback unit.
package wb_pkg;

   localparam int unsigned DefLanes     = 4;
   localparam int unsigned DefDwidth    = 8;
   localparam int unsigned DefAwidth    = 10;
   localparam int unsigned DefFifoDepth = 4;
   localparam int unsigned DefCntWidth  = 8;

   typedef enum logic [1:0] {
      StIdle,
      StActive,
      StDone
   } wb_state_e;

endpackage

// File: rtl/output_writeback_unit_if.sv
// Row stream, matmul read request and BRAM port of the output writeback unit.
interface output_writeback_unit_if
   import wb_pkg::*;
#(
   parameter int unsigned LANES  = DefLanes,
   parameter int unsigned DWIDTH = DefDwidth,
   parameter int unsigned AWIDTH = DefAwidth
);

   logic                    in_valid;
   logic [LANES*DWIDTH-1:0] in_data;
   logic [LANES-1:0]        in_mask;
   logic                    in_ready;
   logic                    rd_req;
   logic [AWIDTH-1:0]       rd_addr;
   logic [AWIDTH-1:0]       bram_addr;
   logic [LANES*DWIDTH-1:0] bram_wdata;
   logic [LANES-1:0]        bram_we;

   modport master (
      output in_valid, in_data, in_mask, rd_req, rd_addr,
      input  in_ready, bram_addr, bram_wdata, bram_we
   );

   modport slave (
      input  in_valid, in_data, in_mask, rd_req, rd_addr,
      output in_ready, bram_addr, bram_wdata, bram_we
   );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous row FIFO with registered full/empty and wrap-bit pointers.
module wb_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   // A pop in the same cycle frees the slot a push on a full FIFO lands in.
   assign do_pop  = pop && !empty_q;
   assign do_push = push && (!full_q || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= (wr_ptr_d[PtrW] != rd_ptr_d[PtrW]) &&
                     (wr_ptr_d[PtrW-1:0] == rd_ptr_d[PtrW-1:0]);
         empty_q  <= (wr_ptr_d == rd_ptr_d);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
   end

   assign head  = mem_q[rd_ptr_q[PtrW-1:0]];
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/output_writeback_unit.sv
// Buffers result rows and writes them to strided BRAM addresses, yielding to matmul reads.
// Define WB_LANE_MASK_EN to store in_mask with each row and use it as the lane write enable.
module output_writeback_unit
   import wb_pkg::*;
#(
   parameter int unsigned LANES      = DefLanes,
   parameter int unsigned DWIDTH     = DefDwidth,
   parameter int unsigned AWIDTH     = DefAwidth,
   parameter int unsigned FIFO_DEPTH = DefFifoDepth,
   parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [AWIDTH-1:0]    base_addr,
   input  logic [AWIDTH-1:0]    addr_stride,
   input  logic [CNT_WIDTH-1:0] num_rows,
   output_writeback_unit_if.slave bus,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned DataW = LANES * DWIDTH;
`ifdef WB_LANE_MASK_EN
   localparam int unsigned EntryW = DataW + LANES;
`else
   localparam int unsigned EntryW = DataW;
`endif

   wb_state_e            state_q, state_d;
   logic [AWIDTH-1:0]    wr_addr_q, wr_addr_d;
   logic [AWIDTH-1:0]    stride_q, stride_d;
   logic [CNT_WIDTH-1:0] num_rows_q, num_rows_d;
   logic [CNT_WIDTH-1:0] accepted_q, accepted_d;
   logic [CNT_WIDTH-1:0] written_q, written_d;

   logic              push, pop;
   logic              fifo_full, fifo_empty;
   logic [EntryW-1:0] fifo_wdata, fifo_head;
   logic [LANES-1:0]  lane_we;

   assign pop = (state_q == StActive) && !fifo_empty && !bus.rd_req;
   assign bus.in_ready = (state_q == StActive) && (accepted_q < num_rows_q) &&
                         (!fifo_full || pop);
   assign push = bus.in_valid && bus.in_ready;

`ifdef WB_LANE_MASK_EN
   assign fifo_wdata = {bus.in_mask, bus.in_data};
   assign lane_we    = fifo_head[EntryW-1 -: LANES];
`else
   logic unused_mask;
   assign unused_mask = ^bus.in_mask;
   assign fifo_wdata  = bus.in_data;
   assign lane_we     = '1;
`endif

   wb_fifo #(
      .WIDTH (EntryW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (fifo_wdata),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      wr_addr_d  = wr_addr_q;
      stride_d   = stride_q;
      num_rows_d = num_rows_q;
      accepted_d = accepted_q;
      written_d  = written_q;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               wr_addr_d  = base_addr;
               stride_d   = addr_stride;
               num_rows_d = num_rows;
               accepted_d = '0;
               written_d  = '0;
               state_d    = (num_rows == '0) ? StDone : StActive;
            end
         end
         StActive: begin
            busy = 1'b1;
            if (push) accepted_d = accepted_q + 1'b1;
            if (pop) begin
               wr_addr_d = wr_addr_q + stride_q;
               written_d = written_q + 1'b1;
               if (CNT_WIDTH'(written_q + 1'b1) == num_rows_q) state_d = StDone;
            end
         end
         StDone: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // The BRAM port follows the matmul read address whenever no row is being written.
   always_comb begin
      bus.bram_addr  = bus.rd_addr;
      bus.bram_wdata = '0;
      bus.bram_we    = '0;
      if (pop) begin
         bus.bram_addr  = wr_addr_q;
         bus.bram_wdata = fifo_head[DataW-1:0];
         bus.bram_we    = lane_we;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         wr_addr_q  <= '0;
         stride_q   <= '0;
         num_rows_q <= '0;
         accepted_q <= '0;
         written_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         stride_q   <= stride_d;
         num_rows_q <= num_rows_d;
         accepted_q <= accepted_d;
         written_q  <= written_d;
      end
   end

endmodule
